piso_bit_feeder: RTL and testbench

PISO_BIT_FEEDER -- requirements
Module: piso_bit_feeder

---
 rtl/piso_bit_feeder.sv | 112 +++++++++++
 tb/tb_piso_bit_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_feeder.sv
// Parallel-in / serial-out bit feeder for a downstream sequence detector.
// Define PISO_BIT_FEEDER_PARITY_EN to append an even-parity bit to every frame.
module piso_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);
  // state | meaning
  // IDLE  | no frame, x/x_valid low, ready for a word
  // SHIFT | presenting data bit cnt of the captured word
  // PAR   | presenting the parity bit (parity builds only)

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef PISO_BIT_FEEDER_PARITY_EN
  localparam bit PARITY = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  localparam bit PARITY = 1'b0;
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             x_nxt, x_valid_nxt, done_nxt;
  logic             load;

  // Bit i of the frame, honouring the configured bit order.
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] i);
    logic [CW-1:0] idx;
    idx = (MSB_FIRST != 0) ? (LAST - i) : i;
    return w[idx];
  endfunction

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    cnt_nxt     = cnt;
    x_nxt       = 1'b0;
    x_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
    load_ready  = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        if (cnt != LAST) begin
          cnt_nxt     = cnt + 1'b1;
          x_nxt       = pick(sreg, cnt + 1'b1);
          x_valid_nxt = 1'b1;
          done_nxt    = !PARITY && ((cnt + 1'b1) == LAST);
        end else begin
`ifdef PISO_BIT_FEEDER_PARITY_EN
          state_nxt   = PAR;
          x_nxt       = ^sreg;
          x_valid_nxt = 1'b1;
          done_nxt    = 1'b1;
`else
          load_ready  = 1'b1;
          state_nxt   = IDLE;
`endif
        end
      end
`ifdef PISO_BIT_FEEDER_PARITY_EN
      PAR: begin
        load_ready = 1'b1;
        state_nxt  = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // A load overrides whatever the current state would do next.
    load = load_valid && load_ready;
    if (load) begin
      state_nxt   = SHIFT;
      sreg_nxt    = din;
      cnt_nxt     = '0;
      x_nxt       = pick(din, '0);
      x_valid_nxt = 1'b1;
      done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      cnt     <= cnt_nxt;
      x       <= x_nxt;
      x_valid <= x_valid_nxt;
      done    <= done_nxt;
    end
  end
endmodule

// File: tb/tb_piso_bit_feeder.sv
// Scoreboard bench: MSB-first and LSB-first feeders share stimulus; a monitor checks
// every cycle against frames expanded from the loaded words.
module tb_piso_bit_feeder;
  localparam int W = 8;
`ifdef PISO_BIT_FEEDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {logic x; logic d;} exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         rdy_m, x_m, xv_m, done_m;
  logic         rdy_l, x_l, xv_l, done_l;

  exp_t  sb_m[$];
  exp_t  sb_l[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    pos = 0;
  logic [2:0]  hist = '0;
  logic [15:0] mask = '0;
  logic [15:0] last_mask = '0;

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(rdy_m), .x(x_m), .x_valid(xv_m), .done(done_m));

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(rdy_l), .x(x_l), .x_valid(xv_l), .done(done_l));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expand a word into its frame: data bits in both orders, then optional even parity.
  function automatic void push_frame(input logic [W-1:0] w);
    int n;
    logic bm, bl;
    n = W + PAR;
    for (int i = 0; i < n; i++) begin
      if (i < W) begin
        bm = w[W-1-i];
        bl = w[i];
      end else begin
        bm = logic'($countones(w) % 2);
        bl = bm;
      end
      sb_m.push_back('{x: bm, d: (i == n - 1)});
      sb_l.push_back('{x: bl, d: (i == n - 1)});
    end
  endfunction

  // Monitor: the feeder must be busy exactly while frame bits remain queued.
  always @(negedge clk) begin
    exp_t e;
    if (sb_m.size() > 0) begin
      e = sb_m.pop_front();
      chk("msb_x_valid", 32'(xv_m), 32'd1);
      chk("msb_x", 32'(x_m), 32'(e.x));
      chk("msb_done", 32'(done_m), 32'(e.d));
    end else begin
      chk("msb_idle_x_valid", 32'(xv_m), 32'd0);
      chk("msb_idle_x", 32'(x_m), 32'd0);
      chk("msb_idle_done", 32'(done_m), 32'd0);
    end
    if (sb_l.size() > 0) begin
      e = sb_l.pop_front();
      chk("lsb_x_valid", 32'(xv_l), 32'd1);
      chk("lsb_x", 32'(x_l), 32'(e.x));
      chk("lsb_done", 32'(done_l), 32'(e.d));
    end else begin
      chk("lsb_idle_x_valid", 32'(xv_l), 32'd0);
    end
    chk("msb_load_ready", 32'(rdy_m), 32'(sb_m.size() == 0));
    chk("lsb_load_ready", 32'(rdy_l), 32'(sb_l.size() == 0));

    // Downstream overlapping "101" detector on the MSB-first stream.
    if (reset) begin
      pos = 0; hist = '0; mask = '0;
    end else if (xv_m) begin
      hist = {hist[1:0], x_m};
      pos++;
      if (pos >= 3 && hist == 3'b101) mask[pos-1] = 1'b1;
      if (done_m) begin
        last_mask = mask; mask = '0; pos = 0; hist = '0;
      end
    end
  end

  task automatic step(input logic lv, input logic [W-1:0] d, output bit acc);
    @(negedge clk); #1;
    load_valid = lv;
    din = d;
    acc = lv && (sb_m.size() == 0) && !reset;
    if (acc) push_frame(d);
  endtask

  // Hold load_valid with the word until the model says it was taken.
  task automatic load(input logic [W-1:0] d);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 40) begin
      step(1'b1, d, acc);
      tries++;
    end
    if (!acc) chk("load_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), acc);
  endtask

  // Asynchronous reset somewhere inside a low clock phase.
  task automatic do_reset();
    #1;
    reset = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("rst_msb_x_valid", 32'(xv_m), 32'd0);
    chk("rst_lsb_x_valid", 32'(xv_l), 32'd0);
    chk("rst_msb_x", 32'(x_m), 32'd0);
    chk("rst_done", 32'(done_m), 32'd0);
    chk("rst_load_ready", 32'(rdy_m), 32'd1);
    sb_m.delete();
    sb_l.delete();
  endtask

  initial begin
    bit acc;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_x_valid", 32'(xv_m), 32'd0);
    chk("reset_load_ready", 32'(rdy_m), 32'd1);
    reset = 1'b0;

    load(8'hA5); idle(10);
    load(8'h01); idle(10);
    load(8'hFF); load(8'h00); idle(12);

    load(8'hA5);
    idle(3);
    do_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    load_valid = 1'b1;
    din = 8'h0F;
    push_frame(8'h0F);
    idle(12);

    load(8'h07); idle(11);
    load(8'hAA); idle(11);
    chk("detector_101_hits", 32'(last_mask), 32'h0054);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
        @(negedge clk); #1;
        reset = 1'b0;
      end else begin
        step(logic'($urandom_range(0, 3) != 0), W'($urandom), acc);
      end
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
